demux_of_destiny: RTL and testbench
===================================

# demux_of_destiny

Registered 1-to-8 distributor: the inverse of the 8-way operand mux. One 32-bit word arrives with a 4-bit select and is delivered to one of eight output channels. Each channel holds one word behind a valid/ready handshake. It sits on the ALU result path and fans one result out to eight consumers; illegal selects (8–15) are dropped, flagged and counted.

## Interface
- `WIDTH`, 32, data width per channel
- `NCH`, 8, number of output channels (fixed at 8; select is 4 bits)
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  input word present
- `in_ready`  out  1  block accepts input this cycle
- `in_data`  in  WIDTH  word to deliver
- `in_sel`  in  4  destination channel; 0–7 legal, 8–15 illegal
- `out_valid`  out  NCH  per-channel word held
- `out_ready`  in  NCH  per-channel consumer takes word
- `out_data`  out  NCH*WIDTH  flattened; channel k occupies bits [WIDTH*k+WIDTH-1 : WIDTH*k]
- `clear_err`  in  1  synchronous clear of `err_sel` and `drop_count`
- `err_sel`  out  1  sticky: an illegal-select word was accepted
- `drop_count`  out  8  saturating count of dropped words

## Operation
- Accept condition: `in_valid && in_ready` at a rising edge.
- `in_ready` is combinational from `in_sel`, `out_valid` and `out_ready`:
  - Legal sel k: `in_ready = !out_valid[k] || out_ready[k]`.
  - Illegal sel: `in_ready = 1`; the word is always accepted and discarded.
- Legal accept to channel k: next cycle `out_valid[k]=1` and channel k data = `in_data`. No other channel changes.
- Channel drain: `out_valid[k] && out_ready[k]` clears `out_valid[k]` next cycle unless channel k also accepts that cycle.
- Simultaneous drain and accept on channel k: the old word is consumed, the new word is loaded, and `out_valid[k]` stays 1 with no bubble.
- Channel k data holds stable while `out_valid[k]`. Data is not cleared on drain; it keeps the last value.
- Illegal accept:
  - `err_sel` is set next cycle.
  - `drop_count` increments and saturates at 255.
  - No channel changes.
- `clear_err`:
  - Next cycle `err_sel=0` and `drop_count=0`.
  - If an illegal accept occurs in the same cycle, clear wins for the count, which becomes 0. `err_sel` is then 1, because the new event is recorded after the clear.
- `out_ready[k]` while `out_valid[k]=0` is ignored.
- Only one channel can load per cycle. Any number of channels can drain per cycle.

## Timing
- Reset (async assert, any time): `out_valid=0`, `out_data=0`, `err_sel=0`, `drop_count=0`. Buffered words are discarded.
- Reset deassertion is synchronous to `clk`. First accept is possible on the first rising edge with `rst_n=1`.
- `in_ready` during reset is don't-care; accepts are ignored.
- Latency: 1 cycle from accept to `out_valid[k]`.
- Throughput:
  - 1 word/cycle when targeting drained channels.
  - 1 word/cycle to the same channel if its consumer holds `out_ready[k]=1`.
- Back-pressure: with `out_valid[k]=1` and `out_ready[k]=0`, any input targeting k stalls (`in_ready=0`). Inputs targeting other channels are unaffected.
- Input side follows a valid/ready contract. The source must hold `in_data`/`in_sel` stable while `in_valid && !in_ready`. The block does not check this.

## Test plan
- Reset then route:
  - Stimulus: with all `out_ready=1`, send sel 0..7 with data 2**sel on consecutive cycles.
  - Required: each channel k shows `out_valid[k]` for exactly one cycle, one cycle after its accept, with data 2**k.
  - Required: `in_ready` stays 1 throughout; `err_sel=0` at the end.
- Back-pressure:
  - Stimulus: hold `out_ready[3]=0`, send 0xA to sel 3, then 0xB to sel 3.
  - Required: the second word stalls with `in_ready=0` and channel 3 holds 0xA.
  - Required: a word sent to sel 5 meanwhile is accepted.
  - Stimulus: raise `out_ready[3]`.
  - Required: 0xB is accepted and appears on channel 3 the next cycle.
- Drain plus reload:
  - Stimulus: channel 2 holds 0x11 and the consumer has `out_ready[2]=1`; send 0x22 to sel 2 in the same cycle.
  - Required: `out_valid[2]` stays 1 with no gap and data becomes 0x22.
- Illegal selects:
  - Stimulus: send sel 8, 15 and 9.
  - Required: all accepted, no `out_valid` change, `err_sel=1`, `drop_count=3`.
  - Stimulus: 300 illegal words.
  - Required: `drop_count=255`.
  - Stimulus: `clear_err` together with one illegal word.
  - Required: `drop_count=0`, `err_sel=1`.
- Async reset mid-operation:
  - Stimulus: with channels 1 and 6 full and `drop_count=4`, pulse `rst_n` low between clock edges.
  - Required: all outputs are 0 immediately, with no clock needed.
  - Required: after release, the next accept to sel 1 behaves normally.

Source files
------------

// File: rtl/demux_of_destiny_if.sv
// Valid/ready bundle between the ALU result source and the 1-to-8 distributor.
// The master drives the input word and the consumer ready lines; the slave is the distributor.
interface demux_of_destiny_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [3:0]           in_sel;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_ready;
  logic [NCH*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_of_destiny.sv
// Registered 1-to-8 distributor: one word per cycle is steered into a one-deep buffer per channel.
// Illegal selects (8-15) are accepted and discarded, raising a sticky flag and a saturating drop count.
module demux_of_destiny #(
  parameter int WIDTH = 32,
  parameter int NCH   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_of_destiny_if.slave  bus,
  input  logic               clear_err,
  output logic               err_sel,
  output logic [7:0]         drop_count
);

  logic [NCH-1:0]       valid_q, valid_d;
  logic [NCH*WIDTH-1:0] data_q, data_d;
  logic                 err_q, err_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 sel_legal;
  logic [2:0]           sel_idx;
  logic                 in_ready;
  logic                 accept;

  always_comb begin
    sel_legal = !bus.in_sel[3];
    sel_idx   = bus.in_sel[2:0];
    in_ready  = 1'b1;
    if (sel_legal) begin
      in_ready = !valid_q[sel_idx] || bus.out_ready[sel_idx];
    end
    accept = bus.in_valid && in_ready;

    // Drain first, then let a same-cycle load overwrite so a busy channel never bubbles.
    valid_d = valid_q & ~bus.out_ready;
    data_d  = data_q;
    if (accept && sel_legal) begin
      valid_d[sel_idx]               = 1'b1;
      data_d[sel_idx*WIDTH +: WIDTH] = bus.in_data;
    end

    err_d = err_q;
    cnt_d = cnt_q;
    if (clear_err) begin
      err_d = 1'b0;
      cnt_d = 8'd0;
    end
    // A drop in the clearing cycle still sets the flag, but the count stays cleared.
    if (accept && !sel_legal) begin
      err_d = 1'b1;
      if (!clear_err && cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign err_sel       = err_q;
  assign drop_count    = cnt_q;

endmodule

// File: tb/tb_demux_of_destiny.sv
// Directed bench for demux_of_destiny: routing, back-pressure, drain+reload,
// illegal-select accounting and asynchronous reset, with hand-computed expectations.
module tb_demux_of_destiny;

  logic       clk;
  logic       rst_n;
  logic       clear_err;
  logic       err_sel;
  logic [7:0] drop_count;
  int         vectors;
  int         miscompares;

  demux_of_destiny_if #(.WIDTH(32), .NCH(8)) bus ();

  demux_of_destiny #(.WIDTH(32), .NCH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clear_err  (clear_err),
    .err_sel    (err_sel),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] chan(input int k);
    return bus.out_data[32*k +: 32];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] sel, input logic [31:0] data);
    bus.in_valid = valid;
    bus.in_sel   = sel;
    bus.in_data  = data;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    clear_err   = 1'b0;
    bus.out_ready = 8'h00;
    applyStimulus(1'b0, 4'd0, 32'h0);

    // Reset state
    #12;
    checkOutput("rst_valid", {24'h0, bus.out_valid}, 32'h0);
    checkOutput("rst_err", {31'h0, err_sel}, 32'h0);
    checkOutput("rst_cnt", {24'h0, drop_count}, 32'h0);
    for (int k = 0; k < 8; k++) checkOutput($sformatf("rst_data%0d", k), chan(k), 32'h0);
    #1 rst_n = 1'b1;
    next_cycle();

    // Route sel 0..7 with all consumers ready
    bus.out_ready = 8'hFF;
    for (int s = 0; s < 8; s++) begin
      applyStimulus(1'b1, 4'(s), 32'h1 << s);
      #1;
      checkOutput($sformatf("route_rdy%0d", s), {31'h0, bus.in_ready}, 32'h1);
      next_cycle();
      checkOutput($sformatf("route_valid%0d", s), {24'h0, bus.out_valid}, 32'h1 << s);
      checkOutput($sformatf("route_data%0d", s), chan(s), 32'h1 << s);
    end
    applyStimulus(1'b0, 4'd0, 32'h0);
    next_cycle();
    checkOutput("route_drained", {24'h0, bus.out_valid}, 32'h0);
    checkOutput("route_err", {31'h0, err_sel}, 32'h0);

    // Back-pressure on channel 3
    bus.out_ready = 8'hF7;
    applyStimulus(1'b1, 4'd3, 32'hA);
    next_cycle();
    checkOutput("bp_ch3_a", chan(3), 32'hA);
    applyStimulus(1'b1, 4'd3, 32'hB);
    #1;
    checkOutput("bp_stall", {31'h0, bus.in_ready}, 32'h0);
    next_cycle();
    checkOutput("bp_hold_valid", {24'h0, bus.out_valid}, 32'h08);
    checkOutput("bp_hold_data", chan(3), 32'hA);
    applyStimulus(1'b1, 4'd5, 32'h5);
    #1;
    checkOutput("bp_sel5_rdy", {31'h0, bus.in_ready}, 32'h1);
    next_cycle();
    checkOutput("bp_sel5_valid", {24'h0, bus.out_valid}, 32'h28);
    checkOutput("bp_sel5_data", chan(5), 32'h5);
    applyStimulus(1'b1, 4'd3, 32'hB);
    #1;
    checkOutput("bp_still_stall", {31'h0, bus.in_ready}, 32'h0);
    bus.out_ready = 8'hFF;
    #1;
    checkOutput("bp_release_rdy", {31'h0, bus.in_ready}, 32'h1);
    next_cycle();
    checkOutput("bp_b_valid", {24'h0, bus.out_valid}, 32'h08);
    checkOutput("bp_b_data", chan(3), 32'hB);
    applyStimulus(1'b0, 4'd0, 32'h0);
    next_cycle();
    checkOutput("bp_drained", {24'h0, bus.out_valid}, 32'h0);

    // Drain plus reload on channel 2
    bus.out_ready = 8'hFB;
    applyStimulus(1'b1, 4'd2, 32'h11);
    next_cycle();
    checkOutput("dr_first", chan(2), 32'h11);
    bus.out_ready = 8'hFF;
    applyStimulus(1'b1, 4'd2, 32'h22);
    #1;
    checkOutput("dr_rdy", {31'h0, bus.in_ready}, 32'h1);
    next_cycle();
    checkOutput("dr_nobubble", {24'h0, bus.out_valid}, 32'h04);
    checkOutput("dr_data", chan(2), 32'h22);
    applyStimulus(1'b0, 4'd0, 32'h0);
    next_cycle();
    checkOutput("dr_empty", {24'h0, bus.out_valid}, 32'h0);
    checkOutput("dr_data_kept", chan(2), 32'h22);

    // Illegal selects
    bus.out_ready = 8'h00;
    applyStimulus(1'b1, 4'd8, 32'hDEAD);
    #1 checkOutput("ill_rdy8", {31'h0, bus.in_ready}, 32'h1);
    next_cycle();
    applyStimulus(1'b1, 4'd15, 32'hBEEF);
    #1 checkOutput("ill_rdy15", {31'h0, bus.in_ready}, 32'h1);
    next_cycle();
    applyStimulus(1'b1, 4'd9, 32'hCAFE);
    next_cycle();
    applyStimulus(1'b0, 4'd0, 32'h0);
    checkOutput("ill_valid", {24'h0, bus.out_valid}, 32'h0);
    checkOutput("ill_err", {31'h0, err_sel}, 32'h1);
    checkOutput("ill_cnt3", {24'h0, drop_count}, 32'd3);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 4'd12, 32'(i));
      next_cycle();
    end
    checkOutput("ill_sat", {24'h0, drop_count}, 32'd255);
    clear_err = 1'b1;
    applyStimulus(1'b1, 4'd10, 32'h0);
    next_cycle();
    checkOutput("clr_cnt", {24'h0, drop_count}, 32'd0);
    checkOutput("clr_err_set", {31'h0, err_sel}, 32'h1);
    applyStimulus(1'b0, 4'd0, 32'h0);
    next_cycle();
    checkOutput("clr_err_gone", {31'h0, err_sel}, 32'h0);
    checkOutput("clr_cnt_idle", {24'h0, drop_count}, 32'd0);
    clear_err = 1'b0;

    // Async reset mid-operation
    applyStimulus(1'b1, 4'd1, 32'h1111);
    next_cycle();
    applyStimulus(1'b1, 4'd6, 32'h6666);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'd11, 32'h0);
      next_cycle();
    end
    applyStimulus(1'b0, 4'd0, 32'h0);
    checkOutput("ar_pre_valid", {24'h0, bus.out_valid}, 32'h42);
    checkOutput("ar_pre_cnt", {24'h0, drop_count}, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", {24'h0, bus.out_valid}, 32'h0);
    checkOutput("ar_err", {31'h0, err_sel}, 32'h0);
    checkOutput("ar_cnt", {24'h0, drop_count}, 32'h0);
    checkOutput("ar_data1", chan(1), 32'h0);
    checkOutput("ar_data6", chan(6), 32'h0);
    #2 rst_n = 1'b1;
    next_cycle();
    applyStimulus(1'b1, 4'd1, 32'hABCD);
    next_cycle();
    applyStimulus(1'b0, 4'd0, 32'h0);
    checkOutput("ar_post_valid", {24'h0, bus.out_valid}, 32'h02);
    checkOutput("ar_post_data", chan(1), 32'hABCD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
